// File: rtl/execute_stage.sv
// execute_stage: execute (X) stage of a 5-stage RISC-V pipeline.
// Takes the decoded instruction from the decode/execute register and forwards
// MEM/WB results into rs1/rs2. It computes ALU, LUI/AUIPC and link results,
// resolves branches and jumps, and runs a 32-step shift-add multiplier.
// Results go to the execute/memory register through a valid/ready handshake.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   valid_i / ready_o              upstream handshake
//   PC_i, immediate_i              64-bit PC and sign-extended immediate
//   readData1_i/2_i, rs1/rs2/rd_i  register operands and indices
//   RegWrite/MemWrite/MemRead/MemToReg/ALUSrc_i, ALUOp_i, funct3_i,
//   funct7b5_i, mul_i              decoded control
//   fwd_mem_*, fwd_wb_*            forwarding sources
//   valid_o / ready_i              downstream handshake
//   result_o, store_data_o, rd_o, RegWrite/MemWrite/MemRead/MemToReg_o,
//   funct3_o                       execute/memory payload
//   flush_o, redirect_pc_o         one-cycle taken-control-flow redirect
module execute_stage #(
    parameter int MulCycles = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] PC_i,
    input  logic [63:0] immediate_i,
    input  logic [31:0] readData1_i,
    input  logic [31:0] readData2_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic        MemToReg_i,
    input  logic        ALUSrc_i,
    input  logic [2:0]  ALUOp_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        mul_i,
    input  logic [4:0]  fwd_mem_rd_i,
    input  logic [31:0] fwd_mem_data_i,
    input  logic        fwd_mem_we_i,
    input  logic [4:0]  fwd_wb_rd_i,
    input  logic [31:0] fwd_wb_data_i,
    input  logic        fwd_wb_we_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o,
    output logic        MemToReg_o,
    output logic [2:0]  funct3_o,
    output logic        flush_o,
    output logic [63:0] redirect_pc_o
);

    typedef enum logic [1:0] {EMPTY, MUL_BUSY, FULL} state_t;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_RTYPE  = 3'b010;
    localparam logic [2:0] OP_IARITH = 3'b011;
    localparam logic [2:0] OP_LUI    = 3'b100;
    localparam logic [2:0] OP_AUIPC  = 3'b101;
    localparam logic [2:0] OP_JAL    = 3'b110;
    localparam logic [2:0] OP_JALR   = 3'b111;
    localparam logic [4:0] MUL_LAST  = 5'(MulCycles - 1);

    function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic do_sub,
                                             input logic arith, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        alu_calc = '0;
        case (f3)
            3'b000: begin
                if (do_sub) alu_calc = a - b;
                else        alu_calc = a + b;
            end
            3'b001: alu_calc = a << sh;
            3'b010: alu_calc = {31'd0, sa < sb};
            3'b011: alu_calc = {31'd0, a < b};
            3'b100: alu_calc = a ^ b;
            3'b101: begin
                if (arith) alu_calc = sa >>> sh;
                else       alu_calc = a >> sh;
            end
            3'b110: alu_calc = a | b;
            default: alu_calc = a & b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'b000:  br_taken = (a == b);
            3'b001:  br_taken = (a != b);
            3'b100:  br_taken = (sa < sb);
            3'b101:  br_taken = (sa >= sb);
            3'b110:  br_taken = (a < b);
            3'b111:  br_taken = (a >= b);
            default: br_taken = 1'b0;
        endcase
    endfunction

    state_t      state, state_next;
    logic        accept;
    logic [31:0] op_a, rs2_val, op_b, result_c;
    logic        taken_c, is_mul, is_branch;
    logic [63:0] target_c;

    logic        vld_p1, flush_p1;
    logic [63:0] redirect_p1;
    logic [31:0] result_p1, store_p1;
    logic [4:0]  rd_p1;
    logic        regwrite_p1, memwrite_p1, memread_p1, memtoreg_p1;
    logic [2:0]  funct3_p1;
    logic [4:0]  cnt_p1;
    logic [31:0] mcand_p1, mplier_p1, acc_p1, acc_next;

    assign is_mul    = (ALUOp_i == OP_RTYPE) & mul_i;
    assign is_branch = (ALUOp_i == OP_BRANCH);
    assign op_b      = ALUSrc_i ? immediate_i[31:0] : rs2_val;
    assign acc_next  = acc_p1 + (mplier_p1[0] ? mcand_p1 : 32'd0);

    // Forwarding: x0 never forwards; the younger MEM result beats WB.
    always_comb begin
        op_a = readData1_i;
        if (rs1_i != 5'd0) begin
            if (fwd_mem_we_i && fwd_mem_rd_i == rs1_i)     op_a = fwd_mem_data_i;
            else if (fwd_wb_we_i && fwd_wb_rd_i == rs1_i)  op_a = fwd_wb_data_i;
        end
        rs2_val = readData2_i;
        if (rs2_i != 5'd0) begin
            if (fwd_mem_we_i && fwd_mem_rd_i == rs2_i)     rs2_val = fwd_mem_data_i;
            else if (fwd_wb_we_i && fwd_wb_rd_i == rs2_i)  rs2_val = fwd_wb_data_i;
        end
    end

    always_comb begin
        result_c = '0;
        taken_c  = 1'b0;
        target_c = PC_i + immediate_i;
        case (ALUOp_i)
            OP_ADD:    result_c = op_a + immediate_i[31:0];
            OP_BRANCH: taken_c  = br_taken(funct3_i, op_a, rs2_val);
            OP_RTYPE:  result_c = alu_calc(funct3_i, funct7b5_i, funct7b5_i, op_a, op_b);
            OP_IARITH: result_c = alu_calc(funct3_i, 1'b0, funct7b5_i, op_a, op_b);
            OP_LUI:    result_c = immediate_i[31:0];
            OP_AUIPC:  result_c = PC_i[31:0] + immediate_i[31:0];
            OP_JAL: begin
                result_c = PC_i[31:0] + 32'd4;
                taken_c  = 1'b1;
            end
            default: begin
                result_c = PC_i[31:0] + 32'd4;
                taken_c  = 1'b1;
                target_c = ({32'd0, op_a} + immediate_i) & ~64'd1;
            end
        endcase
    end

    // FSM: next state and upstream ready; a pending flush blocks acceptance.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        case (state)
            EMPTY:   ready_o = ~flush_p1;
            FULL:    ready_o = ready_i & ~flush_p1;
            default: ready_o = 1'b0;
        endcase
        accept = valid_i & ready_o;
        case (state)
            EMPTY, FULL: begin
                if (accept)                     state_next = is_mul ? MUL_BUSY : FULL;
                else if (state == FULL && ready_i) state_next = EMPTY;
            end
            default: begin
                if (cnt_p1 == MUL_LAST) state_next = FULL;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= EMPTY;
        else         state <= state_next;
    end

    // Stage boundary X -> execute/memory register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p1      <= 1'b0;
            flush_p1    <= 1'b0;
            redirect_p1 <= '0;
            result_p1   <= '0;
            store_p1    <= '0;
            rd_p1       <= '0;
            regwrite_p1 <= 1'b0;
            memwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memtoreg_p1 <= 1'b0;
            funct3_p1   <= '0;
            cnt_p1      <= '0;
        end else begin
            flush_p1 <= accept & taken_c;
            if (accept & taken_c) redirect_p1 <= target_c;
            if (accept) begin
                vld_p1      <= ~is_mul;
                result_p1   <= result_c;
                store_p1    <= rs2_val;
                rd_p1       <= rd_i;
                regwrite_p1 <= RegWrite_i & ~is_branch;
                memwrite_p1 <= MemWrite_i & ~is_branch;
                memread_p1  <= MemRead_i;
                memtoreg_p1 <= MemToReg_i;
                funct3_p1   <= funct3_i;
                cnt_p1      <= '0;
            end else if (state == MUL_BUSY) begin
                cnt_p1 <= cnt_p1 + 5'd1;
                if (cnt_p1 == MUL_LAST) begin
                    vld_p1    <= 1'b1;
                    result_p1 <= acc_next;
                end
            end else if (state == FULL && ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Multiplier datapath: operands captured at accept, one shift-add per cycle
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mcand_p1  <= op_a;
            mplier_p1 <= op_b;
            acc_p1    <= '0;
        end else if (state == MUL_BUSY) begin
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
            acc_p1    <= acc_next;
        end
    end

    assign valid_o       = vld_p1;
    assign flush_o       = flush_p1;
    assign redirect_pc_o = redirect_p1;
    assign result_o      = result_p1;
    assign store_data_o  = store_p1;
    assign rd_o          = rd_p1;
    assign RegWrite_o    = regwrite_p1;
    assign MemWrite_o    = memwrite_p1;
    assign MemRead_o     = memread_p1;
    assign MemToReg_o    = memtoreg_p1;
    assign funct3_o      = funct3_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: table of single-instruction vectors with a
// scoreboard checked at the output handshake, plus hand-written sequences for
// reset, flush, multiply latency, reset-during-multiply and back-pressure.
module tb_execute_stage;

    logic        clk_i = 1'b0;
    logic        reset_i, valid_i, ready_o, ready_i;
    logic [63:0] PC_i, immediate_i, redirect_pc_o;
    logic [31:0] readData1_i, readData2_i, fwd_mem_data_i, fwd_wb_data_i;
    logic [31:0] result_o, store_data_o;
    logic [4:0]  rs1_i, rs2_i, rd_i, fwd_mem_rd_i, fwd_wb_rd_i, rd_o;
    logic        RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i;
    logic [2:0]  ALUOp_i, funct3_i, funct3_o;
    logic        funct7b5_i, mul_i, fwd_mem_we_i, fwd_wb_we_i;
    logic        valid_o, RegWrite_o, MemWrite_o, MemRead_o, MemToReg_o, flush_o;

    execute_stage #(.MulCycles(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .PC_i(PC_i), .immediate_i(immediate_i),
        .readData1_i(readData1_i), .readData2_i(readData2_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .MemToReg_i(MemToReg_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .funct3_i(funct3_i), .funct7b5_i(funct7b5_i), .mul_i(mul_i),
        .fwd_mem_rd_i(fwd_mem_rd_i), .fwd_mem_data_i(fwd_mem_data_i), .fwd_mem_we_i(fwd_mem_we_i),
        .fwd_wb_rd_i(fwd_wb_rd_i), .fwd_wb_data_i(fwd_wb_data_i), .fwd_wb_we_i(fwd_wb_we_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .store_data_o(store_data_o), .rd_o(rd_o),
        .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
        .MemToReg_o(MemToReg_o), .funct3_o(funct3_o),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        mul;
        logic        alusrc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2;
        logic [63:0] imm, pc;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        mwe;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        wwe;
        logic        chkres;
        logic [31:0] res;
        logic        eflush;
        logic [63:0] etgt;
    } vec_t;

    typedef struct {
        int          idx;
        logic        chkres;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        flush;
        logic [63:0] tgt;
    } want_t;

    localparam int NV = 22;
    vec_t  tbl[NV];
    want_t sb[$];
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                                 input logic mul, input logic alusrc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [63:0] imm, input logic [63:0] pc, input logic chkres,
                                 input logic [31:0] res, input logic eflush, input logic [63:0] etgt);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.mul = mul; v.alusrc = alusrc;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = 5'd3; v.d1 = d1; v.d2 = d2;
        v.imm = imm; v.pc = pc;
        v.mrd = 5'd0; v.mdat = 32'd0; v.mwe = 1'b0;
        v.wrd = 5'd0; v.wdat = 32'd0; v.wwe = 1'b0;
        v.chkres = chkres; v.res = res; v.eflush = eflush; v.etgt = etgt;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        PC_i = v.pc; immediate_i = v.imm;
        readData1_i = v.d1; readData2_i = v.d2;
        rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
        RegWrite_i = 1'b1; MemWrite_i = (v.op == 3'b001); MemRead_i = 1'b0; MemToReg_i = 1'b0;
        ALUSrc_i = v.alusrc; ALUOp_i = v.op; funct3_i = v.f3; funct7b5_i = v.f7; mul_i = v.mul;
        fwd_mem_rd_i = v.mrd; fwd_mem_data_i = v.mdat; fwd_mem_we_i = v.mwe;
        fwd_wb_rd_i = v.wrd; fwd_wb_data_i = v.wdat; fwd_wb_we_i = v.wwe;
        valid_i = 1'b1;
    endtask

    function automatic want_t mkwant(input vec_t v, input int idx);
        want_t w;
        w.idx = idx; w.chkres = v.chkres; w.res = v.res; w.rd = v.rd;
        w.rw = (v.op != 3'b001); w.flush = v.eflush; w.tgt = v.etgt;
        return w;
    endfunction

    // Drives one instruction and waits (bounded) for the accepting edge.
    task automatic send(input vec_t v, input int idx, input bit push);
        apply(v);
        #1;
        for (int k = 0; k < 200; k++) begin
            if (ready_o) begin
                if (push) sb.push_back(mkwant(v, idx));
                @(posedge clk_i); #1;
                return;
            end
            @(posedge clk_i); #1;
        end
        chk($sformatf("accept_timeout_%0d", idx), 64'(ready_o), 64'd1);
    endtask

    // Scoreboard: one entry retires per output handshake.
    always @(negedge clk_i) begin
        if (!reset_i && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(valid_o), 64'd0);
            end else begin
                want_t w;
                w = sb.pop_front();
                if (w.chkres) chk($sformatf("result_%0d", w.idx), 64'(result_o), 64'(w.res));
                chk($sformatf("rd_%0d", w.idx), 64'(rd_o), 64'(w.rd));
                chk($sformatf("regwrite_%0d", w.idx), 64'(RegWrite_o), 64'(w.rw));
                chk($sformatf("memwrite_%0d", w.idx), 64'(MemWrite_o), 64'd0);
                chk($sformatf("flush_%0d", w.idx), 64'(flush_o), 64'(w.flush));
                if (w.flush) chk($sformatf("redirect_%0d", w.idx), redirect_pc_o, w.tgt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vm;
        int   busy, seen;

        tbl[0]  = mkv(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 64'd0, 64'd0, 1'b1, 32'd107, 1'b0, 64'd0);
        tbl[0].mrd = 5'd1; tbl[0].mdat = 32'd100; tbl[0].mwe = 1'b1;
        tbl[0].wrd = 5'd1; tbl[0].wdat = 32'd200; tbl[0].wwe = 1'b1;
        tbl[1]  = mkv(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 64'd0, 64'd0, 1'b1, 32'd55, 1'b0, 64'd0);
        tbl[1].wrd = 5'd2; tbl[1].wdat = 32'd50; tbl[1].wwe = 1'b1;
        tbl[2]  = mkv(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 32'd0, 32'd3, 64'd0, 64'd0, 1'b1, 32'd3, 1'b0, 64'd0);
        tbl[2].mrd = 5'd0; tbl[2].mdat = 32'd99; tbl[2].mwe = 1'b1;
        tbl[3]  = mkv(3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd1, 64'd0, 64'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 64'd0);
        tbl[4]  = mkv(3'd2, 3'd5, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h80000000, 32'd4, 64'd0, 64'd0, 1'b1, 32'hF8000000, 1'b0, 64'd0);
        tbl[5]  = mkv(3'd2, 3'd5, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'h80000000, 32'd4, 64'd0, 64'd0, 1'b1, 32'h08000000, 1'b0, 64'd0);
        tbl[6]  = mkv(3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd1, 32'hFFFFFFFF, 64'd0, 64'd0, 1'b1, 32'd1, 1'b0, 64'd0);
        tbl[7]  = mkv(3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd1, 32'hFFFFFFFF, 64'd0, 64'd0, 1'b1, 32'd0, 1'b0, 64'd0);
        tbl[8]  = mkv(3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 32'd10, 32'd0, 64'hFFFFFFFFFFFFFFFD, 64'd0, 1'b1, 32'd7, 1'b0, 64'd0);
        tbl[9]  = mkv(3'd3, 3'd4, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 32'h0000F0F0, 32'd0, 64'hFF, 64'd0, 1'b1, 32'h0000F00F, 1'b0, 64'd0);
        tbl[10] = mkv(3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd1, 32'h21, 64'd0, 64'd0, 1'b1, 32'd2, 1'b0, 64'd0);
        tbl[11] = mkv(3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 64'h12345000, 64'd0, 1'b1, 32'h12345000, 1'b0, 64'd0);
        tbl[12] = mkv(3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 64'h10, 64'h1000, 1'b1, 32'h1010, 1'b0, 64'd0);
        tbl[13] = mkv(3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 32'h100, 32'd0, 64'd8, 64'd0, 1'b1, 32'h108, 1'b0, 64'd0);
        tbl[14] = mkv(3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd3, 32'd4, 64'h20, 64'h100, 1'b0, 32'd0, 1'b1, 64'h120);
        tbl[15] = mkv(3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd3, 32'd4, 64'h20, 64'h100, 1'b0, 32'd0, 1'b0, 64'd0);
        tbl[16] = mkv(3'd1, 3'd4, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFFFFFFFF, 32'd1, 64'hFFFFFFFFFFFFFFF0, 64'h200, 1'b0, 32'd0, 1'b1, 64'h1F0);
        tbl[17] = mkv(3'd1, 3'd7, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd1, 32'hFFFFFFFF, 64'h20, 64'h200, 1'b0, 32'd0, 1'b0, 64'd0);
        tbl[18] = mkv(3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 64'h100, 64'h40, 1'b1, 32'h44, 1'b1, 64'h140);
        tbl[19] = mkv(3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 32'h1001, 32'd0, 64'd4, 64'h40, 1'b1, 32'h44, 1'b1, 64'h1004);
        tbl[20] = mkv(3'd2, 3'd7, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFF00FF00, 32'h0FF00FF0, 64'd0, 64'd0, 1'b1, 32'h0F000F00, 1'b0, 64'd0);
        tbl[21] = mkv(3'd2, 3'd6, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'hFF00FF00, 32'h0FF00FF0, 64'd0, 64'd0, 1'b1, 32'hFFF0FFF0, 1'b0, 64'd0);
        for (int i = 0; i < NV; i++) tbl[i].rd = 5'(i + 1);

        // Reset with a live instruction offered: nothing may leak through.
        reset_i = 1'b1;
        ready_i = 1'b1;
        apply(tbl[0]);
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_flush", 64'(flush_o), 64'd0);
        chk("reset_result", 64'(result_o), 64'd0);
        chk("reset_store", 64'(store_data_o), 64'd0);
        chk("reset_rd", 64'(rd_o), 64'd0);
        chk("reset_regwrite", 64'(RegWrite_o), 64'd0);
        chk("reset_funct3", 64'(funct3_o), 64'd0);
        chk("reset_redirect", redirect_pc_o, 64'd0);
        reset_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("reset_ready", 64'(ready_o), 64'd1);
        @(posedge clk_i); #1;

        // Table vectors, back-to-back where the handshake allows.
        for (int i = 0; i < NV; i++) begin
            send(tbl[i], i, 1'b1);
            if (tbl[i].eflush) chk($sformatf("ready_in_flush_%0d", i), 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;

        // Multiply: latency, busy window, forward changes during busy ignored.
        vm = mkv(3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 32'h12345678, 32'h10, 64'd0, 64'd0, 1'b1, 32'h23456780, 1'b0, 64'd0);
        vm.rd = 5'd9;
        send(vm, 100, 1'b1);
        valid_i = 1'b0;
        readData1_i = 32'hDEADBEEF;
        fwd_mem_rd_i = 5'd1; fwd_mem_data_i = 32'h0BADF00D; fwd_mem_we_i = 1'b1;
        busy = 0;
        for (int k = 1; k <= 32; k++) begin
            if (!ready_o && !valid_o) busy++;
            @(posedge clk_i); #1;
        end
        chk("mul_busy_cycles", 64'(busy), 64'd32);
        chk("mul_valid_t33", 64'(valid_o), 64'd1);
        chk("mul_result_t33", 64'(result_o), 64'h23456780);
        repeat (2) @(posedge clk_i);
        #1;

        // Reset in the middle of a multiply aborts it.
        send(vm, 101, 1'b0);
        valid_i = 1'b0;
        repeat (9) begin @(posedge clk_i); #1; end
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        chk("mul_abort_ready", 64'(ready_o), 64'd1);
        seen = 0;
        repeat (40) begin
            if (valid_o) seen++;
            @(posedge clk_i); #1;
        end
        chk("mul_abort_novalid", 64'(seen), 64'd0);

        // Back-pressure: outputs frozen, then back-to-back accept.
        va = mkv(3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd20, 32'd22, 64'd0, 64'd0, 1'b1, 32'd42, 1'b0, 64'd0);
        vb = mkv(3'd2, 3'd4, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 32'h0000AAAA, 32'h00005555, 64'd0, 64'd0, 1'b1, 32'h0000FFFF, 1'b0, 64'd0);
        vb.rd = 5'd17;
        ready_i = 1'b0;
        send(va, 200, 1'b1);
        apply(vb);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_ready_%0d", k), 64'(ready_o), 64'd0);
            chk($sformatf("stall_valid_%0d", k), 64'(valid_o), 64'd1);
            chk($sformatf("stall_result_%0d", k), 64'(result_o), 64'd42);
            chk($sformatf("stall_store_%0d", k), 64'(store_data_o), 64'd22);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        #1;
        chk("b2b_ready", 64'(ready_o), 64'd1);
        sb.push_back(mkwant(vb, 201));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        chk("b2b_valid", 64'(valid_o), 64'd1);
        chk("b2b_result", 64'(result_o), 64'h0000FFFF);
        repeat (4) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
